fp_reg_file_sb: RTL and testbench
=================================

Name: fp_reg_file_sb

Overview:
Parametrised floating-point register file for the F/D pipeline, successor to the fixed 32x32 FP register file.
- Width, depth and f0 behaviour are configurable.
- Adds a second write port for the long-latency FDIV/FSQRT unit, write-to-read bypass, and NaN-boxing of single-precision results when FLEN=64.
- Adds a per-register pending scoreboard that produces an issue-stall signal for the ID stage.

Parameters:
FLEN, 32, register width; legal values 32 or 64.
NREG, 32, number of registers; power of 2, range 8..32.
AW, $clog2(NREG), address width (derived, not overridden).
ZERO_F0, 0, 1 = f0 is hardwired zero (legacy mode); 0 = f0 is a normal writable register (RISC-V F).

Ports:
i_clk  in  1  clock, posedge.
i_rst_n  in  1  reset, asynchronous, active-low.
i_wa_en  in  1  write port A enable (main pipeline WB).
i_wa_addr  in  AW  port A address.
i_wa_data  in  FLEN  port A data.
i_wa_sp  in  1  port A data is single precision (low 32 bits valid).
i_wb_en  in  1  write port B enable (long-latency unit).
i_wb_addr  in  AW  port B address.
i_wb_data  in  FLEN  port B data.
i_wb_sp  in  1  port B single precision.
i_rs1_addr, i_rs2_addr, i_rs3_addr  in  AW each  read addresses.
i_rs_use  in  3  source-used flags for rs1/rs2/rs3 of the instruction in ID.
i_iss_en  in  1  long-latency op issues this cycle.
i_iss_rd  in  AW  destination of the issuing long-latency op.
i_flush_pend  in  1  synchronous clear of all pending bits.
o_rs1_data, o_rs2_data, o_rs3_data  out  FLEN each  read data.
o_hazard  out  1  ID must stall.
o_pend_vec  out  NREG  pending bit per register.

Behaviour:
Reset:
- While i_rst_n is low, all registers are 0 and all pending bits are 0.
- o_rs*_data then show 0; o_hazard and o_pend_vec are 0.

Writes:
- Registers update on the posedge of i_clk.
- Write data is formatted first. If sp=1 and FLEN=64, the stored value is {32'hFFFF_FFFF, data[31:0]}; otherwise data is stored as is.
- If port A and port B target the same address in the same cycle, port A wins and port B's data is dropped.
- When ZERO_F0=1, writes to address 0 are ignored and reads of address 0 return 0.

Reads:
- Reads are combinational with bypass.
- If i_wa_en is high and i_wa_addr matches the read address, return the formatted port A data.
- Otherwise, if i_wb_en is high and i_wb_addr matches, return the formatted port B data.
- Otherwise return the stored value.
- The bypass is suppressed for address 0 when ZERO_F0=1.

Scoreboard:
- Posedge with i_iss_en=1 sets pend[i_iss_rd].
- Posedge with i_wb_en=1 clears pend[i_wb_addr].
- Set and clear on the same address in the same cycle: set wins, because it is a new issue.
- A port A write does not touch pending bits.
- i_flush_pend=1 clears all pending bits at the posedge. An i_iss_en in the same cycle still sets its bit.

Hazard (combinational):
- For each source n where i_rs_use[n]=1: hazard if pend[rsn] is set and the source is not being written by port B this cycle. A port B write this cycle is covered by the bypass.
- WAW: when i_iss_en=1 and pend[i_iss_rd]=1 and no port B write to i_iss_rd this cycle, o_hazard=1.
- When o_hazard=1 because of WAW, the issue is ignored and the pending bit is left unchanged.
- With ZERO_F0=1, address 0 never sets a pending bit and never causes a hazard.

Reset mid-operation:
- Asserting reset clears pending bits immediately (asynchronously).
- A late port B write after reset writes the register normally.

Latency:
- Write to read via bypass: 0 cycles.
- Pending bit visible on o_pend_vec: 1 cycle after issue.

Test Plan:
- Reset, then read all addresses -> all 0, o_hazard=0, o_pend_vec=0.
- FLEN=64: port A writes f5=0x3F80_0000 with sp=1; the same cycle reads f5 -> 0xFFFFFFFF_3F800000, and the next cycle still returns the same value.
- Port A and port B both write f7 (0x11, 0x22) in the same cycle -> f7=0x11 the next cycle; a same-cycle read of f7 returns 0x11.
- Issue f3; next cycle i_rs1_addr=3 with i_rs_use=001 -> o_hazard=1. Port B writes f3=0xABCD -> o_hazard=0 that cycle, o_rs1_data=0xABCD, pend[3]=0 the next cycle.
- pend[4]=1 and i_iss_en with i_iss_rd=4 -> o_hazard=1 and the pend vector is unchanged. Same setup with port B writing f4 in that cycle -> issue accepted, pend[4]=1.
- ZERO_F0=1: write f0=0x55 -> read 0; issue to f0 -> o_pend_vec[0]=0. ZERO_F0=0: write f0=0x55 -> read 0x55.

Source files
------------

// File: rtl/fp_reg_file_sb.sv
// Parametrised FP register file: two write ports (pipeline WB and long-latency unit),
// bypassed combinational reads, NaN-boxing of single-precision results, pending scoreboard.
module fp_reg_file_sb #(
    parameter int FLEN    = 32,
    parameter int NREG    = 32,
    parameter int ZERO_F0 = 0,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wa_en,
    input  logic [AW-1:0]   i_wa_addr,
    input  logic [FLEN-1:0] i_wa_data,
    input  logic            i_wa_sp,
    input  logic            i_wb_en,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [FLEN-1:0] i_wb_data,
    input  logic            i_wb_sp,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    input  logic [AW-1:0]   i_rs3_addr,
    input  logic [2:0]      i_rs_use,
    input  logic            i_iss_en,
    input  logic [AW-1:0]   i_iss_rd,
    input  logic            i_flush_pend,
    output logic [FLEN-1:0] o_rs1_data,
    output logic [FLEN-1:0] o_rs2_data,
    output logic [FLEN-1:0] o_rs3_data,
    output logic            o_hazard,
    output logic [NREG-1:0] o_pend_vec
);

    logic [FLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_next;
    logic [FLEN-1:0] wa_fmt;
    logic [FLEN-1:0] wb_fmt;
    logic [AW-1:0]   rs_addr [3];
    logic [FLEN-1:0] rs_data [3];
    logic            wa_ok;
    logic            wb_ok;
    logic            raw;
    logic            waw;
    logic            iss_ok;

    function automatic logic hard_zero(input logic [AW-1:0] a);
        return (ZERO_F0 != 0) && (a == '0);
    endfunction

    // Single-precision results are NaN-boxed only when the register is wider than 32 bits.
    if (FLEN == 64) begin : g_box
        assign wa_fmt = i_wa_sp ? {32'hFFFF_FFFF, i_wa_data[31:0]} : i_wa_data;
        assign wb_fmt = i_wb_sp ? {32'hFFFF_FFFF, i_wb_data[31:0]} : i_wb_data;
    end else begin : g_nobox
        logic unused_sp;
        assign unused_sp = i_wa_sp ^ i_wb_sp;
        assign wa_fmt    = i_wa_data;
        assign wb_fmt    = i_wb_data;
    end

    assign wa_ok = i_wa_en && !hard_zero(i_wa_addr);
    assign wb_ok = i_wb_en && !hard_zero(i_wb_addr) && !(wa_ok && (i_wa_addr == i_wb_addr));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wa_ok) begin
                regs[i_wa_addr] <= wa_fmt;
            end
            if (wb_ok) begin
                regs[i_wb_addr] <= wb_fmt;
            end
        end
    end

    assign rs_addr[0] = i_rs1_addr;
    assign rs_addr[1] = i_rs2_addr;
    assign rs_addr[2] = i_rs3_addr;

    // Later assignments take priority: port A over port B over the stored value.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            rs_data[n] = regs[rs_addr[n]];
            if (i_wb_en && (i_wb_addr == rs_addr[n])) begin
                rs_data[n] = wb_fmt;
            end
            if (i_wa_en && (i_wa_addr == rs_addr[n])) begin
                rs_data[n] = wa_fmt;
            end
            if (hard_zero(rs_addr[n])) begin
                rs_data[n] = '0;
            end
        end
    end

    assign o_rs1_data = rs_data[0];
    assign o_rs2_data = rs_data[1];
    assign o_rs3_data = rs_data[2];

    // A source being written by port B this cycle is served by the bypass, so it does not stall.
    always_comb begin
        raw = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (i_rs_use[n] && pend[rs_addr[n]] && !hard_zero(rs_addr[n]) &&
                !(i_wb_en && (i_wb_addr == rs_addr[n]))) begin
                raw = 1'b1;
            end
        end
    end

    assign waw      = i_iss_en && pend[i_iss_rd] && !(i_wb_en && (i_wb_addr == i_iss_rd));
    assign iss_ok   = i_iss_en && !waw && !hard_zero(i_iss_rd);
    assign o_hazard = raw | waw;

    // Clear before set so a new issue wins over a completion or flush on the same register.
    always_comb begin
        pend_next = pend;
        if (i_flush_pend) begin
            pend_next = '0;
        end
        if (i_wb_en) begin
            pend_next[i_wb_addr] = 1'b0;
        end
        if (iss_ok) begin
            pend_next[i_iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    assign o_pend_vec = pend;

endmodule

// File: tb/tb_fp_reg_file_sb.sv
// Directed bench for fp_reg_file_sb: a 64-bit writable-f0 instance driven from a vector
// table, plus a 32-bit hardwired-f0 instance sharing the same stimulus.
module tb_fp_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wa_en = 1'b0;
    logic [4:0]  wa_addr = '0;
    logic [63:0] wa_data = '0;
    logic        wa_sp = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [63:0] wb_data = '0;
    logic        wb_sp = 1'b0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [4:0]  rs3 = '0;
    logic [2:0]  rs_use = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        flush = 1'b0;

    logic [63:0] d_rs1, d_rs2, d_rs3;
    logic        d_hz;
    logic [31:0] d_pend;
    logic [31:0] z_rs1, z_rs2, z_rs3;
    logic        z_hz;
    logic [31:0] z_pend;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fp_reg_file_sb #(.FLEN(64), .NREG(32), .ZERO_F0(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data), .i_wa_sp(wa_sp),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_sp(wb_sp),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rs3_addr(rs3), .i_rs_use(rs_use),
        .i_iss_en(iss_en), .i_iss_rd(iss_rd), .i_flush_pend(flush),
        .o_rs1_data(d_rs1), .o_rs2_data(d_rs2), .o_rs3_data(d_rs3),
        .o_hazard(d_hz), .o_pend_vec(d_pend)
    );

    fp_reg_file_sb #(.FLEN(32), .NREG(32), .ZERO_F0(1)) dut_z (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data[31:0]), .i_wa_sp(wa_sp),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data[31:0]), .i_wb_sp(wb_sp),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rs3_addr(rs3), .i_rs_use(rs_use),
        .i_iss_en(iss_en), .i_iss_rd(iss_rd), .i_flush_pend(flush),
        .o_rs1_data(z_rs1), .o_rs2_data(z_rs2), .o_rs3_data(z_rs3),
        .o_hazard(z_hz), .o_pend_vec(z_pend)
    );

    typedef struct {
        logic        wa_en;
        logic [4:0]  wa_addr;
        logic [63:0] wa_data;
        logic        wa_sp;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [63:0] wb_data;
        logic        wb_sp;
        logic [4:0]  rs1, rs2, rs3;
        logic [2:0]  rs_use;
        logic        iss_en;
        logic [4:0]  iss_rd;
        logic        flush;
        logic [63:0] e1, e2, e3;
        logic        ehz;
        logic [31:0] epend;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t make_vec(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                                      input logic [2:0] u, input logic [63:0] x1, input logic [63:0] x2,
                                      input logic [63:0] x3, input logic hz, input logic [31:0] pv);
        vec_t v;
        v.wa_en = 1'b0; v.wa_addr = '0; v.wa_data = '0; v.wa_sp = 1'b0;
        v.wb_en = 1'b0; v.wb_addr = '0; v.wb_data = '0; v.wb_sp = 1'b0;
        v.iss_en = 1'b0; v.iss_rd = '0; v.flush = 1'b0;
        v.rs1 = r1; v.rs2 = r2; v.rs3 = r3; v.rs_use = u;
        v.e1 = x1; v.e2 = x2; v.e3 = x3; v.ehz = hz; v.epend = pv;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        wa_en = 1'b0; wb_en = 1'b0; wa_sp = 1'b0; wb_sp = 1'b0;
        iss_en = 1'b0; flush = 1'b0; rs_use = 3'b000;
    endtask

    task automatic apply_stimulus(input vec_t v);
        wa_en = v.wa_en; wa_addr = v.wa_addr; wa_data = v.wa_data; wa_sp = v.wa_sp;
        wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data; wb_sp = v.wb_sp;
        rs1 = v.rs1; rs2 = v.rs2; rs3 = v.rs3; rs_use = v.rs_use;
        iss_en = v.iss_en; iss_rd = v.iss_rd; flush = v.flush;
    endtask

    localparam logic [63:0] Z64  = 64'h0;
    localparam logic [63:0] BOX5 = 64'hFFFF_FFFF_3F80_0000;
    localparam logic [63:0] ABCD = 64'h0000_0000_0000_ABCD;
    localparam logic [63:0] H11  = 64'h11;
    localparam logic [63:0] H44  = 64'h44;
    localparam logic [63:0] H55  = 64'h55;
    localparam logic [63:0] RAW6 = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] BOX6 = 64'hFFFF_FFFF_9ABC_DEF0;

    initial begin
        vec_t v;

        v = make_vec(5, 5, 5, 3'b000, BOX5, BOX5, BOX5, 1'b0, 32'h0);
        v.wa_en = 1'b1; v.wa_addr = 5'd5; v.wa_data = 64'h3F80_0000; v.wa_sp = 1'b1; tab.push_back(v);
        v = make_vec(5, 5, 5, 3'b000, BOX5, BOX5, BOX5, 1'b0, 32'h0); tab.push_back(v);
        v = make_vec(7, 7, 7, 3'b000, H11, H11, H11, 1'b0, 32'h0);
        v.wa_en = 1'b1; v.wa_addr = 5'd7; v.wa_data = H11;
        v.wb_en = 1'b1; v.wb_addr = 5'd7; v.wb_data = 64'h22; tab.push_back(v);
        v = make_vec(7, 5, 7, 3'b000, H11, BOX5, H11, 1'b0, 32'h0); tab.push_back(v);
        v = make_vec(0, 0, 0, 3'b000, Z64, Z64, Z64, 1'b0, 32'h8);
        v.iss_en = 1'b1; v.iss_rd = 5'd3; tab.push_back(v);
        v = make_vec(3, 0, 0, 3'b001, Z64, Z64, Z64, 1'b1, 32'h8); tab.push_back(v);
        v = make_vec(3, 3, 3, 3'b001, ABCD, ABCD, ABCD, 1'b0, 32'h0);
        v.wb_en = 1'b1; v.wb_addr = 5'd3; v.wb_data = ABCD; tab.push_back(v);
        v = make_vec(3, 7, 5, 3'b111, ABCD, H11, BOX5, 1'b0, 32'h0); tab.push_back(v);
        v = make_vec(0, 0, 0, 3'b000, Z64, Z64, Z64, 1'b0, 32'h10);
        v.iss_en = 1'b1; v.iss_rd = 5'd4; tab.push_back(v);
        v = make_vec(0, 0, 0, 3'b000, Z64, Z64, Z64, 1'b1, 32'h10);
        v.iss_en = 1'b1; v.iss_rd = 5'd4; tab.push_back(v);
        v = make_vec(4, 4, 4, 3'b000, H44, H44, H44, 1'b0, 32'h10);
        v.iss_en = 1'b1; v.iss_rd = 5'd4; v.wb_en = 1'b1; v.wb_addr = 5'd4; v.wb_data = H44; tab.push_back(v);
        v = make_vec(4, 4, 0, 3'b010, H44, H44, Z64, 1'b1, 32'h10); tab.push_back(v);
        v = make_vec(2, 0, 4, 3'b100, Z64, Z64, H44, 1'b1, 32'h10); tab.push_back(v);
        v = make_vec(2, 2, 4, 3'b011, Z64, Z64, H44, 1'b0, 32'h10); tab.push_back(v);
        v = make_vec(0, 0, 0, 3'b000, Z64, Z64, Z64, 1'b0, 32'h200);
        v.iss_en = 1'b1; v.iss_rd = 5'd9; v.flush = 1'b1; tab.push_back(v);
        v = make_vec(9, 0, 0, 3'b001, Z64, Z64, Z64, 1'b1, 32'h0);
        v.flush = 1'b1; tab.push_back(v);
        v = make_vec(0, 0, 0, 3'b000, H55, H55, H55, 1'b0, 32'h0);
        v.wa_en = 1'b1; v.wa_addr = 5'd0; v.wa_data = H55; tab.push_back(v);
        v = make_vec(0, 3, 0, 3'b000, H55, ABCD, H55, 1'b0, 32'h0); tab.push_back(v);
        v = make_vec(6, 6, 6, 3'b000, BOX6, BOX6, BOX6, 1'b0, 32'h0);
        v.wb_en = 1'b1; v.wb_addr = 5'd6; v.wb_data = RAW6; v.wb_sp = 1'b1; tab.push_back(v);
        v = make_vec(6, 6, 6, 3'b000, RAW6, RAW6, RAW6, 1'b0, 32'h0);
        v.wa_en = 1'b1; v.wa_addr = 5'd6; v.wa_data = RAW6; tab.push_back(v);
        v = make_vec(6, 6, 6, 3'b000, RAW6, RAW6, RAW6, 1'b0, 32'h0); tab.push_back(v);
        v = make_vec(8, 9, 8, 3'b000, 64'h88, 64'h99, 64'h88, 1'b0, 32'h0);
        v.wa_en = 1'b1; v.wa_addr = 5'd8; v.wa_data = 64'h88;
        v.wb_en = 1'b1; v.wb_addr = 5'd9; v.wb_data = 64'h99; tab.push_back(v);
        v = make_vec(9, 8, 0, 3'b000, 64'h99, 64'h88, H55, 1'b0, 32'h0); tab.push_back(v);

        // Reset state, checked both while reset is held and after release.
        repeat (2) @(negedge clk);
        check_output("rst_hold rs1", d_rs1, Z64);
        check_output("rst_hold pend", {32'h0, d_pend}, 64'h0);
        check_output("rst_hold hazard", {63'h0, d_hz}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            rs1 = 5'(a); rs2 = 5'(31 - a); rs3 = 5'(a);
            #1;
            check_output($sformatf("rst rs1 a%0d", a), d_rs1, Z64);
            check_output($sformatf("rst rs2 a%0d", a), d_rs2, Z64);
            check_output($sformatf("rst_z rs3 a%0d", a), {32'h0, z_rs3}, Z64);
        end
        check_output("rst hazard", {63'h0, d_hz}, 64'h0);
        check_output("rst pend", {32'h0, d_pend}, 64'h0);
        check_output("rst_z pend", {32'h0, z_pend}, 64'h0);

        // Table-driven vectors on the 64-bit instance.
        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            apply_stimulus(tab[i]);
            #2;
            check_output($sformatf("v%0d rs1", i), d_rs1, tab[i].e1);
            check_output($sformatf("v%0d rs2", i), d_rs2, tab[i].e2);
            check_output($sformatf("v%0d rs3", i), d_rs3, tab[i].e3);
            check_output($sformatf("v%0d hazard", i), {63'h0, d_hz}, {63'h0, tab[i].ehz});
            @(posedge clk);
            #1;
            check_output($sformatf("v%0d pend", i), {32'h0, d_pend}, {32'h0, tab[i].epend});
        end

        // Hardwired f0: writes to f0 are invisible, including the same-cycle bypass.
        @(negedge clk);
        set_idle();
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 64'h55; rs1 = 5'd0;
        #2;
        check_output("z f0 bypass", {32'h0, z_rs1}, Z64);
        check_output("d f0 bypass", d_rs1, H55);
        @(negedge clk);
        set_idle();
        iss_en = 1'b1; iss_rd = 5'd0;
        #2;
        check_output("z f0 stored", {32'h0, z_rs1}, Z64);
        @(negedge clk);
        set_idle();
        rs1 = 5'd0; rs_use = 3'b001;
        #2;
        check_output("z f0 pend", {32'h0, z_pend}, 64'h0);
        check_output("d f0 pend", {32'h0, d_pend}, 64'h1);
        check_output("z f0 hazard", {63'h0, z_hz}, 64'h0);
        check_output("d f0 hazard", {63'h0, d_hz}, 64'h1);
        flush = 1'b1;
        @(negedge clk);
        set_idle();
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 64'hDEAD_BEEF; wb_sp = 1'b1; rs1 = 5'd2;
        #2;
        check_output("z sp no box", {32'h0, z_rs1}, 64'hDEAD_BEEF);
        check_output("d sp box", d_rs1, 64'hFFFF_FFFF_DEAD_BEEF);
        check_output("d flushed pend", {32'h0, d_pend}, 64'h0);

        // Asynchronous reset in the middle of a cycle, then a late port B completion.
        @(negedge clk);
        set_idle();
        iss_en = 1'b1; iss_rd = 5'd12;
        @(negedge clk);
        set_idle();
        rs1 = 5'd7;
        check_output("mid pend set", {32'h0, d_pend}, 64'h1000);
        #1 rst_n = 1'b0;
        #1;
        check_output("mid rst pend", {32'h0, d_pend}, 64'h0);
        check_output("mid rst rs1", d_rs1, Z64);
        #1 rst_n = 1'b1;
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 64'h1234;
        @(negedge clk);
        set_idle();
        rs1 = 5'd12;
        #1;
        check_output("late wb data", d_rs1, 64'h1234);
        check_output("late wb pend", {32'h0, d_pend}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
